pingpong_sink: RTL

PINGPONG_SINK -- requirements
Module: pingpong_sink

---
 rtl/pingpong_sink_if.sv | 11 +
 rtl/pingpong_sink.sv | 113 +++++++++++
 2 files changed

// File: rtl/pingpong_sink_if.sv
// Valid/ready beat channel between an upstream source and the pingpong sink.
interface pingpong_sink_if #(
    parameter int DATA_WD = 8
) ();
    logic               valid_in;
    logic [DATA_WD-1:0] data_in;
    logic               ready_out;

    modport master (output valid_in, output data_in, input ready_out);
    modport slave  (input valid_in, input data_in, output ready_out);
endinterface

// File: rtl/pingpong_sink.sv
// Sequence-checking sink: accepts incrementing beats under programmable backpressure,
// counts accepted beats and mismatches, and captures the first mismatch.
module pingpong_sink #(
    parameter int          DATA_WD   = 8,
    parameter int          CNT_WD    = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               en,
    input  logic [1:0]         bp_mode,
    input  logic               clr,
    pingpong_sink_if.slave     bus,
    output logic [CNT_WD-1:0]  rx_cnt,
    output logic [CNT_WD-1:0]  err_cnt,
    output logic               err,
    output logic               first_err_vld,
    output logic [DATA_WD-1:0] first_err_exp,
    output logic [DATA_WD-1:0] first_err_got
);

    // An all-zero seed would lock the LFSR, so it is promoted to 1.
    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    localparam logic [1:0] MODE_ALWAYS = 2'd0;
    localparam logic [1:0] MODE_ALT    = 2'd1;
    localparam logic [1:0] MODE_LFSR   = 2'd2;
    localparam logic [1:0] MODE_NEVER  = 2'd3;

    function automatic logic [CNT_WD-1:0] sat_inc(input logic [CNT_WD-1:0] v);
        return (&v) ? v : v + CNT_WD'(1);
    endfunction

    logic               ready_q;
    logic               ready_nxt;
    logic [15:0]        lfsr_q;
    logic               lfsr_fb;
    logic [DATA_WD-1:0] exp_q;
    logic               fire_p0;
    logic               mismatch_p0;

    assign bus.ready_out = ready_q;
    assign fire_p0       = bus.valid_in & ready_q;
    // A beat that arrives together with clr is neither counted nor checked.
    assign mismatch_p0   = fire_p0 & ~clr & (bus.data_in != exp_q);
    assign lfsr_fb       = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

    always_comb begin
        ready_nxt = 1'b0;
        if (en) begin
            case (bp_mode)
                MODE_ALWAYS: ready_nxt = 1'b1;
                MODE_ALT:    ready_nxt = ~ready_q;
                MODE_LFSR:   ready_nxt = lfsr_q[0];
                MODE_NEVER:  ready_nxt = 1'b0;
            endcase
        end
    end

    // Stage p0 -> p1: handshake state, expected-value tracking
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ready_q <= 1'b0;
            lfsr_q  <= SEED;
            exp_q   <= '0;
        end else begin
            ready_q <= ready_nxt;
            lfsr_q  <= {lfsr_fb, lfsr_q[15:1]};
            if (fire_p0) begin
                exp_q <= bus.data_in + DATA_WD'(1);
            end
        end
    end

    // Stage p0 -> p1: statistics
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_cnt  <= '0;
            err_cnt <= '0;
            err     <= 1'b0;
        end else if (clr) begin
            rx_cnt  <= '0;
            err_cnt <= '0;
            err     <= 1'b0;
        end else begin
            if (fire_p0) begin
                rx_cnt <= sat_inc(rx_cnt);
            end
            if (mismatch_p0) begin
                err_cnt <= sat_inc(err_cnt);
                err     <= 1'b1;
            end
        end
    end

    // Stage p0 -> p1: first-mismatch capture
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            first_err_vld <= 1'b0;
            first_err_exp <= '0;
            first_err_got <= '0;
        end else if (clr) begin
            first_err_vld <= 1'b0;
            first_err_exp <= '0;
            first_err_got <= '0;
        end else if (mismatch_p0 && !first_err_vld) begin
            first_err_vld <= 1'b1;
            first_err_exp <= exp_q;
            first_err_got <= bus.data_in;
        end
    end

endmodule
